// File: rtl/link_delay_channel_pkg.sv
// Shared link definitions so the hub, the leaf decoders and the delay channel agree on width.
package link_delay_channel_pkg;

    localparam int unsigned LINK_DATA_WIDTH = 64;

    typedef logic [LINK_DATA_WIDTH-1:0] link_msg_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/link_delay_fifo_mem.sv
// In-flight message store: data plus acceptance timestamp per slot, with valid/mature tracking.
module link_delay_fifo_mem
    import link_delay_channel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LINK_DATA_WIDTH,
    parameter int unsigned DELAY      = 53,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned TS_W       = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TS_W-1:0]       now_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  head_valid_o,
    output logic                  head_mature_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [TS_W-1:0] DelayTs = TS_W'(DELAY);

    logic [DATA_WIDTH+TS_W-1:0] mem_q [DEPTH];
    logic [TS_W-1:0]            age [DEPTH];
    logic [DEPTH-1:0]           valid_q, valid_d, mature_q, mature_d, ripe;
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;

    // Every slot is aged each cycle so a slot waiting behind a blocked head latches maturity
    // before its timestamp difference wraps.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i]  = now_i - mem_q[i][TS_W-1:0];
            ripe[i] = (age[i] >= DelayTs);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        mature_d = mature_q | (valid_q & ripe);
        if (pop_i) begin
            valid_d[rd_ptr_q]  = 1'b0;
            mature_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_ptr_q]  = 1'b1;
            mature_d[wr_ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            mature_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            mature_q <= mature_d;
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= {push_data_i, now_i};
        end
    end

    assign head_valid_o  = valid_q[rd_ptr_q];
    assign head_mature_o = mature_q[rd_ptr_q] | ripe[rd_ptr_q];
    assign head_data_o   = valid_q[rd_ptr_q] ? mem_q[rd_ptr_q][DATA_WIDTH+TS_W-1:TS_W]
                                             : '0;

endmodule

// File: rtl/link_delay_channel.sv
// Fixed-latency valid/ready link channel; LINK_DELAY_STATS_EN adds delivery/stall/peak counters.
module link_delay_channel
    import link_delay_channel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LINK_DATA_WIDTH,
    parameter int unsigned DELAY      = 53,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned TS_W       = $clog2(DELAY + 1) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef LINK_DELAY_STATS_EN
    ,
    output logic [31:0]             stat_msgs,
    output logic [31:0]             stat_stall,
    output logic [$clog2(DEPTH):0]  stat_max_occ
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FullOcc = OCC_W'(DEPTH);

    logic [TS_W-1:0]  now_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_ready_q;
    logic             push, pop, head_valid, head_mature;

    assign push      = in_valid & in_ready_q;
    assign out_valid = head_valid & head_mature;
    assign pop       = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // in_ready is registered from the next occupancy, so a pop at full frees a slot one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            now_q      <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            now_q      <= now_q + TS_W'(1);
            occ_q      <= occ_d;
            in_ready_q <= (occ_d != FullOcc);
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;

    link_delay_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DELAY      (DELAY),
        .DEPTH      (DEPTH),
        .TS_W       (TS_W)
    ) u_mem (
        .clk           (clk),
        .reset         (reset),
        .now_i         (now_q),
        .push_i        (push),
        .push_data_i   (in_data),
        .pop_i         (pop),
        .head_valid_o  (head_valid),
        .head_mature_o (head_mature),
        .head_data_o   (out_data)
    );

`ifdef LINK_DELAY_STATS_EN
    logic [31:0]      msgs_q, stall_q;
    logic [OCC_W-1:0] max_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msgs_q  <= '0;
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            if (pop) begin
                msgs_q <= sat_inc32(msgs_q);
            end
            if (out_valid && !out_ready) begin
                stall_q <= sat_inc32(stall_q);
            end
            if (occ_d > max_q) begin
                max_q <= occ_d;
            end
        end
    end

    assign stat_msgs    = msgs_q;
    assign stat_stall   = stall_q;
    assign stat_max_occ = max_q;
`endif

endmodule

// File: tb/tb_link_delay_channel.sv
// Bench for link_delay_channel: DELAY=53 and DELAY=1 instances against a queue-based latency model.
module tb_link_delay_channel;
    import link_delay_channel_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    link_msg_t in_data [2];
    link_msg_t out_data [2];
    logic      in_valid [2];
    logic      in_ready [2];
    logic      out_valid [2];
    logic      out_ready [2];
    logic [6:0] occ [2];

`ifdef LINK_DELAY_STATS_EN
    logic [31:0] s_msgs [2];
    logic [31:0] s_stall [2];
    logic [6:0]  s_max [2];
`endif

    always #5 clk = ~clk;

    link_delay_channel #(.DELAY(53)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .occupancy(occ[0])
`ifdef LINK_DELAY_STATS_EN
        , .stat_msgs(s_msgs[0]), .stat_stall(s_stall[0]), .stat_max_occ(s_max[0])
`endif
    );

    link_delay_channel #(.DELAY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .occupancy(occ[1])
`ifdef LINK_DELAY_STATS_EN
        , .stat_msgs(s_msgs[1]), .stat_stall(s_stall[1]), .stat_max_occ(s_max[1])
`endif
    );

    // Model: per instance a FIFO of (data, accepting edge index); head deliverable once
    // DELAY-1 edges have passed since its accepting edge.
    int        dly [2] = '{53, 1};
    link_msg_t md [2][256];
    int        mt [2][256];
    int        mh [2] = '{0, 0};
    int        mtl [2] = '{0, 0};
    bit        mrdy [2] = '{1'b0, 1'b0};
    int        edge_n = 0;
    int        checks = 0;
    int        passes = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mh[k]   = mtl[k];
                mrdy[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit ev, do_pop, do_push;
                ev = (mtl[k] - mh[k] > 0) && (edge_n - mt[k][mh[k] % 256] >= dly[k] - 1);
                do_pop  = ev && out_ready[k];
                do_push = in_valid[k] && mrdy[k];
                if (do_pop) mh[k]++;
                if (do_push) begin
                    md[k][mtl[k] % 256] = in_data[k];
                    mt[k][mtl[k] % 256] = edge_n + 1;
                    mtl[k]++;
                end
                mrdy[k] = (mtl[k] - mh[k]) != 64;
            end
            edge_n++;
        end
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", nm, k, act, exp);
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            int n;
            bit ev;
            n  = mtl[k] - mh[k];
            ev = (n > 0) && (edge_n - mt[k][mh[k] % 256] >= dly[k] - 1);
            chk("model_out_valid", k, 64'(out_valid[k]), 64'(ev));
            if (ev) chk("model_out_data", k, out_data[k], md[k][mh[k] % 256]);
            chk("model_occupancy", k, 64'(occ[k]), 64'(n));
            chk("model_in_ready", k, 64'(in_ready[k]), 64'(mrdy[k]));
        end
    endtask

    // One cycle: compare at the falling edge, return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_data[k]   = '0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (3) tick();
        chk("rst_in_ready", 0, 64'(in_ready[0]), 64'd0);
        chk("rst_out_valid", 0, 64'(out_valid[0]), 64'd0);
        chk("rst_out_data", 0, out_data[0], 64'd0);
        chk("rst_occ", 0, 64'(occ[0]), 64'd0);
        #2 reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 0, 64'(in_ready[0]), 64'd1);

        // Single message: accepted at edge B+1, visible after edge B+53, gone after B+54.
        in_valid[0] = 1'b1;
        in_data[0]  = 64'hDEAD_BEEF_0000_0001;
        tick();
        in_valid[0] = 1'b0;
        chk("single_occ_after_push", 0, 64'(occ[0]), 64'd1);
        repeat (51) tick();
        chk("single_not_early", 0, 64'(out_valid[0]), 64'd0);
        tick();
        chk("single_valid_on_time", 0, 64'(out_valid[0]), 64'd1);
        chk("single_data", 0, out_data[0], 64'hDEAD_BEEF_0000_0001);
        tick();
        chk("single_valid_one_cycle", 0, 64'(out_valid[0]), 64'd0);
        chk("single_occ_drained", 0, 64'(occ[0]), 64'd0);

        // Burst to full with the sink blocked, then release.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 64'h1000 + 64'(i);
            tick();
        end
        in_data[0] = 64'h1000 + 64'd64;
        chk("burst_full_in_ready", 0, 64'(in_ready[0]), 64'd0);
        chk("burst_full_occ", 0, 64'(occ[0]), 64'd64);
        repeat (3) tick();
        out_ready[0] = 1'b1;
        tick();
        chk("burst_ready_after_pop", 0, 64'(in_ready[0]), 64'd1);
        chk("burst_occ_after_pop", 0, 64'(occ[0]), 64'd63);
        tick();
        chk("burst_push_pop_occ", 0, 64'(occ[0]), 64'd63);
        in_valid[0] = 1'b0;
        repeat (70) tick();
        chk("burst_drained", 0, 64'(occ[0]), 64'd0);

        // Long stall past timestamp wrap.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 64'h3000 + 64'(i);
            tick();
        end
        in_valid[0] = 1'b0;
        repeat (300) tick();
        chk("stall_valid_held", 0, 64'(out_valid[0]), 64'd1);
        chk("stall_head_data", 0, out_data[0], 64'h3000);
        out_ready[0] = 1'b1;
        tick();
        chk("stall_second", 0, out_data[0], 64'h3001);
        tick();
        chk("stall_third", 0, out_data[0], 64'h3002);
        tick();
        chk("stall_drained", 0, 64'(occ[0]), 64'd0);

        // Asynchronous reset with messages in flight.
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 64'h4000 + 64'(i);
            tick();
        end
        in_valid[0] = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst_out_valid", 0, 64'(out_valid[0]), 64'd0);
        chk("arst_occ", 0, 64'(occ[0]), 64'd0);
        chk("arst_in_ready", 0, 64'(in_ready[0]), 64'd0);
        tick();
        tick();
        #3 reset = 1'b0;
        tick();
        chk("arst_release_ready", 0, 64'(in_ready[0]), 64'd1);
`ifdef LINK_DELAY_STATS_EN
        chk("stat_msgs_reset", 0, 64'(s_msgs[0]), 64'd0);
        // Head matures after 53 edges; sink held off 20 further cycles.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 64'h5000 + 64'(i);
            tick();
        end
        in_valid[0] = 1'b0;
        repeat (68) tick();
        out_ready[0] = 1'b1;
        repeat (10) tick();
        chk("stat_msgs", 0, 64'(s_msgs[0]), 64'd5);
        chk("stat_stall", 0, 64'(s_stall[0]), 64'd20);
        chk("stat_max_occ", 0, 64'(s_max[0]), 64'd5);
`endif
        repeat (60) tick();

        // DELAY=1: one message per cycle, each visible right after its accepting edge.
        for (int i = 0; i < 20; i++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = 64'h6000 + 64'(i);
            tick();
            chk("d1_valid", 1, 64'(out_valid[1]), 64'd1);
            chk("d1_data", 1, out_data[1], 64'h6000 + 64'(i));
            chk("d1_occ_le1", 1, 64'(occ[1] <= 7'd1), 64'd1);
        end
        in_valid[1] = 1'b0;
        tick();
        chk("d1_drained", 1, 64'(occ[1]), 64'd0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/link_delay_channel.md
Name: link_delay_channel

Overview:
- Sits on each 64-bit valid/ready link between the root hub and a leaf decoder (down_tx -> parent_rx, and parent_tx -> up_rx).
- Models inter-FPGA router latency in single-FPGA runs: every accepted message is delivered no earlier than DELAY cycles after acceptance.
- Order is preserved and backpressure is honoured on both sides.
- One instance per direction per leaf.

Parameters:
- DATA_WIDTH, 64, message width in bits.
- DELAY, 53, minimum acceptance-to-delivery latency in cycles; legal range is at least 1.
- DEPTH, 64, number of in-flight message slots; power of two, at least 2.
- TS_W, $clog2(DELAY+1)+1, timestamp counter width (derived; do not override).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  DATA_WIDTH  upstream message
- in_valid  input  1  upstream message valid
- in_ready  output  1  channel can accept a message
- out_data  output  DATA_WIDTH  delivered message
- out_valid  output  1  delivered message valid
- out_ready  input  1  downstream accepts
- occupancy  output  $clog2(DEPTH)+1  messages currently held

Behaviour:
- Reset values: in_ready=0 while reset is asserted, then 1 from the first cycle after deassertion; out_valid=0; out_data=0; occupancy=0. The timestamp counter, pointers and all per-slot valid/mature bits are cleared.
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Acceptance: a message is accepted on a clk edge where in_valid & in_ready.
  - in_ready = !(occupancy == DEPTH), taken from registered state only.
  - No same-cycle bypass when full: a pop at full does not raise in_ready until the next cycle.
- Timestamp: a free-running TS_W-bit counter, now, increments every cycle and wraps. An accepted slot stores ts = now.
- Maturity:
  - A slot is mature once (now - ts) mod 2^TS_W >= DELAY.
  - Each slot keeps a sticky mature bit, set on the first cycle the condition holds and cleared only on pop or reset.
  - This keeps the channel correct when a message waits more than 2^TS_W cycles behind a blocked head.
- Output: out_valid = head slot valid & head mature. out_data = head slot data, registered storage read with no combinational path from in_*.
- Latency: with an empty channel and out_ready=1, a message accepted at edge T is presented with out_valid=1 in the cycle following edge T+DELAY-1, i.e. exactly DELAY edges later. Throughput is one message per cycle.
- Handshake: once out_valid is asserted, out_data and out_valid stay stable until out_valid & out_ready. The same rule applies upstream: the channel never drops a message.
- Simultaneous push and pop: both happen in the same cycle and occupancy is unchanged. At empty, a push is not visible at the output before DELAY cycles.
- Ordering: strict FIFO. A younger mature slot never overtakes an immature or blocked head.
- Reset mid-operation: all in-flight messages are discarded and never appear after reset.

Optional Feature:
- Macro: LINK_DELAY_STATS_EN.
- When defined, adds three outputs:
  - stat_msgs (32-bit): count of delivered messages.
  - stat_stall (32-bit): count of cycles with out_valid & !out_ready.
  - stat_max_occ ($clog2(DEPTH)+1): peak occupancy.
- All three saturate, and reset to 0.
- When not defined, these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package: the LINK_DATA_WIDTH=64 constant and a link message typedef, so that root_hub_test, the leaf and this block agree on width.
- Sub-module: link_delay_fifo_mem, a DEPTH x (DATA_WIDTH+TS_W) storage array with write and read pointers, the per-slot valid and mature bits, and the maturity compare.
- The top level holds the counter, the handshake logic and the stats.

Test Plan:
- Single message, DELAY=53: push 0xDEAD_BEEF_0000_0001 at edge 10 with out_ready=1 -> out_valid first high the cycle after edge 63, held one cycle, data matches, occupancy returns to 0.
- Burst: push 64 messages on consecutive edges -> in_ready=0 after the 64th. Outputs arrive on 64 consecutive cycles, each 53 edges after its push. A 65th push is accepted one cycle after the first pop.
- Long stall: push 3 messages, hold out_ready=0 for 300 cycles, exceeding 2^TS_W=128 -> out_valid high from 53 cycles after the first push, data stable throughout, then all 3 delivered in order on release with no loss or duplication.
- Reset mid-flight: 10 messages in flight, reset pulsed for 2 cycles asynchronously off-edge -> out_valid=0 and occupancy=0 immediately, in_ready=1 after release, none of the 10 messages ever appears.
- DELAY=1 instance: continuous push with out_ready=1 -> one message per cycle, each delivered 1 edge after acceptance, occupancy stays at or below 1.
- With LINK_DELAY_STATS_EN: 5 messages with out_ready low for 20 cycles while the head is mature -> stat_msgs=5, stat_stall=20, stat_max_occ=5.
